// File: rtl/sha256_round_stage_if.sv
// ----------------------------------------------------------------------------
// sha256_round_stage_if
// Bundles the request/response signals of one SHA-256 round stage.
//   en        start request; W, state_in and hash_in are valid with it
//   W         schedule window, word i at bits [i*WORD_S +: WORD_S]
//   state_in  working state a..h, a in the lowest word
//   hash_in   H values added to the final state on the last stage
//   state_out result state, same packing as state_in
//   en_next   one-cycle pulse marking state_out valid
//   busy      rounds in progress
//   overrun   sticky flag: a request arrived while busy
// master: the producer side (schedule stage / bench); slave: the round stage.
// ----------------------------------------------------------------------------
interface sha256_round_stage_if #(
  parameter int WORD_S   = 32,
  parameter int W_BLKCNT = 16
);
  logic                       en;
  logic [W_BLKCNT*WORD_S-1:0] W;
  logic [8*WORD_S-1:0]        state_in;
  logic [8*WORD_S-1:0]        hash_in;
  logic [8*WORD_S-1:0]        state_out;
  logic                       en_next;
  logic                       busy;
  logic                       overrun;

  modport master (
    output en, W, state_in, hash_in,
    input  state_out, en_next, busy, overrun
  );

  modport slave (
    input  en, W, state_in, hash_in,
    output state_out, en_next, busy, overrun
  );
endinterface

// File: rtl/sha256_round_stage.sv
// ----------------------------------------------------------------------------
// sha256_round_stage
// Runs DELAY SHA-256 compression rounds, one per clock, starting at round
// ROUND_BASE, on a latched copy of the working state and schedule window.
// On the last round the result (optionally plus hash_in) is registered onto
// state_out and announced with a one-cycle en_next pulse.
// Ports:
//   clk    clock
//   reset  synchronous, active-high; aborts any operation in flight
//   bus    sha256_round_stage_if.slave (en, W, state_in, hash_in in;
//          state_out, en_next, busy, overrun out)
// ----------------------------------------------------------------------------
module sha256_round_stage #(
  parameter int WORD_S     = 32,
  parameter int W_BLKCNT   = 16,
  parameter int DELAY      = 8,
  parameter int ROUND_BASE = 0,
  parameter int ADD_FINAL  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  sha256_round_stage_if.slave  bus
);

  localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int ST_W  = 8 * WORD_S;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_S-1:0] wbuf_q [DELAY];
  logic [WORD_S-1:0] wbuf_d [DELAY];
  logic [ST_W-1:0]   work_q, work_d;
  logic [ST_W-1:0]   hash_q, hash_d;
  logic [ST_W-1:0]   state_out_q, state_out_d;
  logic              en_next_q, en_next_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic [5:0]        k_idx_s;
  logic [31:0]       k_s;
  logic [31:0]       w_s;
  logic [ST_W-1:0]   round_s;
  logic [ST_W-1:0]   final_s;

  // ---------------------------------------------------------------- helpers
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch_f(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // One compression round; result keeps the a-in-lowest-word packing.
  function automatic logic [255:0] sha_round(input logic [255:0] s,
                                             input logic [31:0]  k,
                                             input logic [31:0]  w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    a  = s[31:0];    b = s[63:32];   c = s[95:64];   d = s[127:96];
    e  = s[159:128]; f = s[191:160]; g = s[223:192]; h = s[255:224];
    t1 = h + big_sigma1(e) + ch_f(e, f, g) + k + w;
    t2 = big_sigma0(a) + maj_f(a, b, c);
    return {g, f, e, d + t1, c, b, a, t1 + t2};
  endfunction

  // Word-wise mod 2^32 addition, no carries across word boundaries.
  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = {256{1'b0}};
    for (int i = 0; i < 8; i++) begin
      r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    end
    return r;
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
      default: k = 32'h00000000;
    endcase
    return k;
  endfunction

  // ------------------------------------------------------------- datapath
  // Round constant and window word for the current round.
  always_comb begin
    k_idx_s = 6'(ROUND_BASE) + 6'(cnt_q);
    k_s     = k_rom(k_idx_s);
    w_s     = wbuf_q[cnt_q];
    round_s = sha_round(work_q, k_s, w_s);
    if (ADD_FINAL != 0) begin
      final_s = add_words(round_s, hash_q);
    end else begin
      final_s = round_s;
    end
  end

  // Next-state and output logic of the IDLE/RUN controller.
  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    wbuf_d      = wbuf_q;
    work_d      = work_q;
    hash_d      = hash_q;
    state_out_d = state_out_q;
    en_next_d   = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;

    case (fsm_q)
      IDLE: begin
        if (bus.en) begin
          for (int i = 0; i < DELAY; i++) begin
            wbuf_d[i] = bus.W[i*WORD_S +: WORD_S];
          end
          work_d = bus.state_in;
          hash_d = bus.hash_in;
          cnt_d  = {CNT_W{1'b0}};
          busy_d = 1'b1;
          fsm_d  = RUN;
        end else begin
          fsm_d = IDLE;
        end
      end
      RUN: begin
        work_d = round_s;
        // A request while running is dropped; latched data stays untouched.
        if (bus.en) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (cnt_q == CNT_LAST) begin
          state_out_d = final_s;
          en_next_d   = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
          fsm_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
        cnt_d  = {CNT_W{1'b0}};
      end
    endcase
  end

  // State register with synchronous reset that wins over every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      for (int i = 0; i < DELAY; i++) begin
        wbuf_q[i] <= {WORD_S{1'b0}};
      end
      work_q      <= {ST_W{1'b0}};
      hash_q      <= {ST_W{1'b0}};
      state_out_q <= {ST_W{1'b0}};
      en_next_q   <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      wbuf_q      <= wbuf_d;
      work_q      <= work_d;
      hash_q      <= hash_d;
      state_out_q <= state_out_d;
      en_next_q   <= en_next_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.state_out = state_out_q;
  assign bus.en_next   = en_next_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sha256_round_stage.sv
// ----------------------------------------------------------------------------
// tb_sha256_round_stage
// Known-answer tests on a DELAY=1 stage and an 8-stage "abc" chain, then
// randomized traffic on a DELAY=8 / ROUND_BASE=24 / ADD_FINAL=1 stage checked
// by a scoreboard fed from a behavioural reference model.
// ----------------------------------------------------------------------------
module tb_sha256_round_stage;
  localparam int DLY   = 8;
  localparam int RB    = 24;
  localparam int NEVER = 32'h3fffffff;
  localparam logic [255:0] H0 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                 32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [255:0] DIGEST = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                     32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  sha256_round_stage_if #(.WORD_S(32), .W_BLKCNT(16)) m_if ();
  sha256_round_stage_if #(.WORD_S(32), .W_BLKCNT(16)) o_if ();

  sha256_round_stage #(.WORD_S(32), .W_BLKCNT(16), .DELAY(DLY), .ROUND_BASE(RB), .ADD_FINAL(1))
    u_main (.clk(clk), .reset(reset), .bus(m_if.slave));
  sha256_round_stage #(.WORD_S(32), .W_BLKCNT(16), .DELAY(1), .ROUND_BASE(0), .ADD_FINAL(0))
    u_one (.clk(clk), .reset(reset), .bus(o_if.slave));

  // 8-stage chain covering all 64 rounds
  logic                  ch_en0;
  logic [71:0][31:0]     wpad;
  logic [7:0]            ch_en;
  logic [7:0][255:0]     ch_st;

  for (genvar gi = 0; gi < 8; gi++) begin : g_chain
    sha256_round_stage_if #(.WORD_S(32), .W_BLKCNT(16)) sif ();
    if (gi == 0) begin : g_first
      assign sif.en       = ch_en0;
      assign sif.state_in = H0;
    end else begin : g_rest
      assign sif.en       = ch_en[gi-1];
      assign sif.state_in = ch_st[gi-1];
    end
    assign sif.W       = wpad[8*gi +: 16];
    assign sif.hash_in = H0;
    assign ch_en[gi]   = sif.en_next;
    assign ch_st[gi]   = sif.state_out;
    sha256_round_stage #(.WORD_S(32), .W_BLKCNT(16), .DELAY(8), .ROUND_BASE(8*gi),
                         .ADD_FINAL((gi == 7) ? 1 : 0))
      u_stg (.clk(clk), .reset(reset), .bus(sif.slave));
  end

  // ------------------------------------------------------ reference model
  logic [31:0] kt [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // First 32 fractional bits of a positive real.
  function automatic logic [31:0] frac32(input real x);
    real f;
    f = x - $floor(x);
    return 32'(longint'($floor(f * 4294967296.0)));
  endfunction

  // n rounds from round 'base'; win word j feeds round base+j.
  function automatic logic [255:0] model_run(input logic [255:0] st, input logic [255:0] hs,
                                             input logic [511:0] win, input int base,
                                             input int n, input bit addf);
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] res;
    for (int q = 0; q < 8; q++) v[q] = st[32*q +: 32];
    for (int j = 0; j < n; j++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[base+j] + win[32*j +: 32];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int q = 7; q > 0; q--) v[q] = v[q-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int q = 0; q < 8; q++) res[32*q +: 32] = addf ? v[q] + hs[32*q +: 32] : v[q];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ------------------------------------------------------ scoreboard state
  typedef struct {
    logic [255:0] st;
    int           cyc;
  } exp_t;
  exp_t         exp_q [$];
  int           free_edge = 0;
  int           last_e0   = -100;
  int           ov_edge   = NEVER;
  logic [255:0] held      = '0;

  // Monitor for the main stage: sampled 1 time unit after each rising edge.
  initial begin : monitor
    exp_t e;
    bit   due;
    forever begin
      @(posedge clk);
      #1;
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("en_next", 256'(m_if.en_next), 256'(due));
      if (due) begin
        e = exp_q.pop_front();
        chk("state_out", m_if.state_out, e.st);
        held = e.st;
      end else begin
        chk("state_out hold", m_if.state_out, held);
      end
      chk("busy", 256'(m_if.busy), 256'((cyc >= last_e0) && (cyc < last_e0 + DLY)));
      chk("overrun", 256'(m_if.overrun), 256'(cyc >= ov_edge));
    end
  end

  // One cycle of main-stage stimulus, driven on the falling edge.
  task automatic step_main(input bit en_v);
    int           edge_n;
    logic [255:0] r;
    m_if.en = en_v;
    for (int i = 0; i < 16; i++) m_if.W[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++) begin
      m_if.state_in[32*i +: 32] = $urandom;
      m_if.hash_in[32*i +: 32]  = $urandom;
    end
    edge_n = cyc + 1;
    if (en_v) begin
      if (edge_n >= free_edge) begin
        r = model_run(m_if.state_in, m_if.hash_in, m_if.W, RB, DLY, 1'b1);
        exp_q.push_back('{r, edge_n + DLY});
        last_e0   = edge_n;
        free_edge = edge_n + DLY + 1;
      end else if (edge_n < ov_edge) begin
        ov_edge = edge_n;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int ncyc);
    reset   = 1'b1;
    m_if.en = 1'b0;
    exp_q.delete();
    last_e0 = -100;
    ov_edge = NEVER;
    held    = '0;
    repeat (ncyc) @(negedge clk);
    reset     = 1'b0;
    free_edge = cyc + 1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ stimulus
  initial begin : stim
    int  p, np, g, t0, n;
    bit  isp;
    logic [255:0] r;

    m_if.en = 1'b0; m_if.W = '0; m_if.state_in = '0; m_if.hash_in = '0;
    o_if.en = 1'b0; o_if.W = '0; o_if.state_in = '0; o_if.hash_in = '0;
    ch_en0 = 1'b0;

    // K from cube roots of the first 64 primes
    p = 2; np = 0;
    while (np < 64) begin
      isp = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) isp = 1'b0;
      if (isp) begin
        kt[np] = frac32($pow(real'(p), 1.0 / 3.0));
        np++;
      end
      p++;
    end

    // Message schedule for the padded single block "abc"
    wpad = '0;
    wpad[0]  = 32'h61626380;
    wpad[15] = 32'h00000018;
    for (int t = 16; t < 64; t++)
      wpad[t] = ssig1(wpad[t-2]) + wpad[t-7] + ssig0(wpad[t-15]) + wpad[t-16];

    @(negedge clk);
    do_reset(3);

    // Single-round stage known answer
    o_if.state_in   = H0;
    o_if.W          = '0;
    o_if.W[31:0]    = 32'h61626380;
    o_if.en         = 1'b1;
    @(negedge clk);
    o_if.en = 1'b0;
    chk("one busy", 256'(o_if.busy), 256'(1));
    chk("one en_next early", 256'(o_if.en_next), 256'(0));
    @(negedge clk);
    chk("one en_next", 256'(o_if.en_next), 256'(1));
    chk("one a", 256'(o_if.state_out[31:0]), 256'(32'h5d6aebcd));
    chk("one e", 256'(o_if.state_out[159:128]), 256'(32'hfa2a4622));
    chk("one b", 256'(o_if.state_out[63:32]), 256'(32'h6a09e667));
    chk("one h", 256'(o_if.state_out[255:224]), 256'(32'h1f83d9ab));
    chk("one model", o_if.state_out, model_run(H0, '0, o_if.W, 0, 1, 1'b0));
    @(negedge clk);
    chk("one en_next width", 256'(o_if.en_next), 256'(0));

    // Chain digest of "abc"
    ch_en0 = 1'b1;
    @(negedge clk);
    ch_en0 = 1'b0;
    t0 = cyc;
    n  = 0;
    while (n < 100 && !ch_en[7]) begin
      @(negedge clk);
      n++;
    end
    chk("chain latency", 256'(cyc - t0), 256'(71));
    chk("chain digest", ch_st[7], DIGEST);
    r = H0;
    for (int s = 0; s < 8; s++) r = model_run(r, H0, wpad[8*s +: 16], 8*s, 8, s == 7);
    chk("chain model", ch_st[7], r);

    // Main stage: back-to-back and en-in-en_next-cycle, no overrun expected
    for (int k = 0; k < 12; k++) begin
      step_main(1'b1);
      g = (k % 2 == 0) ? DLY : DLY + int'($urandom_range(1, 3));
      repeat (g) step_main(1'b0);
    end

    // en held high for 20 cycles
    repeat (20) step_main(1'b1);
    repeat (DLY + 2) step_main(1'b0);

    // Reset while cnt==3, then a fresh operation
    step_main(1'b1);
    repeat (3) step_main(1'b0);
    do_reset(2);
    step_main(1'b1);
    repeat (DLY + 2) step_main(1'b0);

    // Random traffic with arbitrary gaps
    for (int k = 0; k < 25; k++) begin
      step_main(1'b1);
      repeat ($urandom_range(0, DLY + 3)) step_main(1'b0);
    end
    repeat (DLY + 3) step_main(1'b0);
    chk("scoreboard drained", 256'(exp_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
